// File: rtl/bus_arbiter_rr_pkg.sv
// bus_arb_pkg -- shared types and constants for the bus_arbiter_rr slice.
//   N_MASTERS  : default master count used by the top and the interface
//   arb_vector : request/grant vector at the default width
//   NO_REQUEST / NO_GRANT : all-zero vectors
//   state_t    : arbiter FSM states
package bus_arb_pkg;

    localparam int N_MASTERS = 4;

    typedef bit [N_MASTERS-1:0] arb_vector;

    localparam arb_vector NO_REQUEST = '0;
    localparam arb_vector NO_GRANT   = '0;

    typedef enum logic {IDLE, BUSY} state_t;

endpackage

// File: rtl/bus_arbiter_rr_if.sv
// bus_arbiter_rr_if -- request/grant bundle between bus masters and the arbiter.
//   bus_req[N]  : per-master level request
//   bus_ack     : slave-side end of tenure
//   bus_grant[N], grant_idx, grant_valid, timeout_err : arbiter outputs
// Modports:
//   master : the bus side (masters + slave ack), drives requests/ack
//   slave  : the arbiter, consumes requests/ack and drives the grant
interface bus_arbiter_rr_if #(
    parameter int N_MASTERS = bus_arb_pkg::N_MASTERS,
    parameter int IDX_W     = $clog2(N_MASTERS)
);
    logic [N_MASTERS-1:0] bus_req;
    logic                 bus_ack;
    logic [N_MASTERS-1:0] bus_grant;
    logic [IDX_W-1:0]     grant_idx;
    logic                 grant_valid;
    logic                 timeout_err;

    modport master (
        output bus_req, bus_ack,
        input  bus_grant, grant_idx, grant_valid, timeout_err
    );

    modport slave (
        input  bus_req, bus_ack,
        output bus_grant, grant_idx, grant_valid, timeout_err
    );
endinterface

// File: rtl/arb_rr_select.sv
// arb_rr_select -- combinational winner picker.
//   req      : request vector
//   rr_ptr   : index of the last granted master (round-robin only)
//   win_oh   : one-hot winner, zero when no request
//   win_idx  : binary index of the winner
//   any_req  : at least one request present
// RR_MODE=0 picks the lowest set index; RR_MODE=1 scans from rr_ptr+1
// upward modulo N_MASTERS, so the last owner is lowest priority.
module arb_rr_select #(
    parameter int N_MASTERS = 4,
    parameter int RR_MODE   = 1,
    parameter int IDX_W     = $clog2(N_MASTERS)
) (
    input  logic [N_MASTERS-1:0] req,
    input  logic [IDX_W-1:0]     rr_ptr,
    output logic [N_MASTERS-1:0] win_oh,
    output logic [IDX_W-1:0]     win_idx,
    output logic                 any_req
);

    assign any_req = |req;

    always_comb begin
        win_oh  = '0;
        win_idx = '0;
        for (int k = 0; k < N_MASTERS; k++) begin
            int j;
            j = (RR_MODE != 0) ? (int'(rr_ptr) + 1 + k) % N_MASTERS : k;
            // First hit in scan order wins; later hits are ignored.
            if (win_oh == '0 && req[j]) begin
                win_oh[j] = 1'b1;
                win_idx   = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/bus_arbiter_rr.sv
// bus_arbiter_rr -- N-master bus arbiter, fixed-priority or round-robin.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus          : bus_arbiter_rr_if.slave (requests/ack in, grant out)
// A grant is registered one cycle after a request seen in IDLE and held
// until bus_ack; an ack with requests pending hands over on the same edge.
// Optional: define BUS_ARBITER_TIMEOUT_EN to add a hold watchdog that forces
// re-arbitration after MAX_HOLD un-acked BUSY cycles and pulses timeout_err.
module bus_arbiter_rr
    import bus_arb_pkg::*;
#(
    parameter int N_MASTERS = bus_arb_pkg::N_MASTERS,
    parameter int RR_MODE   = 1,
    parameter int MAX_HOLD  = 15,
    parameter int IDX_W     = $clog2(N_MASTERS)
) (
    input  logic            clk,
    input  logic            reset_n,
    bus_arbiter_rr_if.slave bus
);

    state_t               state;
    logic [N_MASTERS-1:0] grant_q;
    logic [IDX_W-1:0]     idx_q;
    logic                 valid_q;
    logic [IDX_W-1:0]     rr_ptr;

    logic [N_MASTERS-1:0] win_oh;
    logic [IDX_W-1:0]     win_idx;
    logic                 any_req;
    logic                 timeout_hit;
    logic                 rearb;

    arb_rr_select #(
        .N_MASTERS (N_MASTERS),
        .RR_MODE   (RR_MODE),
        .IDX_W     (IDX_W)
    ) u_sel (
        .req     (bus.bus_req),
        .rr_ptr  (rr_ptr),
        .win_oh  (win_oh),
        .win_idx (win_idx),
        .any_req (any_req)
    );

`ifdef BUS_ARBITER_TIMEOUT_EN
    logic [7:0] hold_cnt;
    logic       to_q;

    // An ack in the same cycle wins over the watchdog.
    assign timeout_hit = (state == BUSY) && !bus.bus_ack && (hold_cnt == 8'(MAX_HOLD));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_cnt <= '0;
            to_q     <= 1'b0;
        end else begin
            to_q <= timeout_hit;
            // Counts un-acked BUSY cycles; any arbitration edge restarts it.
            if (state == BUSY && !rearb)
                hold_cnt <= hold_cnt + 8'd1;
            else
                hold_cnt <= '0;
        end
    end

    assign bus.timeout_err = to_q;
`else
    logic [7:0] unused_max_hold;
    assign unused_max_hold = 8'(MAX_HOLD);
    assign timeout_hit     = 1'b0;
    assign bus.timeout_err = 1'b0;
`endif

    // Re-arbitration point inside a tenure: normal ack or forced timeout.
    assign rearb = bus.bus_ack || timeout_hit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            grant_q <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            rr_ptr  <= IDX_W'(N_MASTERS - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant_q <= win_oh;
                        idx_q   <= win_idx;
                        valid_q <= 1'b1;
                        state   <= BUSY;
                        if (RR_MODE != 0) rr_ptr <= win_idx;
                    end
                end
                BUSY: begin
                    if (rearb && any_req) begin
                        grant_q <= win_oh;
                        idx_q   <= win_idx;
                        valid_q <= 1'b1;
                        if (RR_MODE != 0) rr_ptr <= win_idx;
                    end else if (rearb) begin
                        grant_q <= '0;
                        idx_q   <= '0;
                        valid_q <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.bus_grant   = grant_q;
    assign bus.grant_idx   = idx_q;
    assign bus.grant_valid = valid_q;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Directed bench for bus_arbiter_rr: one fixed-priority and one round-robin
// instance (MAX_HOLD=4), plus a short random invariant sweep on the RR one.
module tb_bus_arbiter_rr;
    import bus_arb_pkg::*;

    logic clk;
    logic reset_n;
    int   errors = 0;
    int   checks = 0;

    bus_arbiter_rr_if #(.N_MASTERS(4)) fif ();
    bus_arbiter_rr_if #(.N_MASTERS(4)) rif ();

    bus_arbiter_rr #(.N_MASTERS(4), .RR_MODE(0), .MAX_HOLD(4)) dut_fp (
        .clk(clk), .reset_n(reset_n), .bus(fif.slave));

    bus_arbiter_rr #(.N_MASTERS(4), .RR_MODE(1), .MAX_HOLD(4)) dut_rr (
        .clk(clk), .reset_n(reset_n), .bus(rif.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] rr_seq [5];
    logic [3:0] prev_grant;
    logic [3:0] prev_req;
    logic       prev_ack;

    initial begin
        rr_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        reset_n = 1'b0;
        fif.bus_req = NO_REQUEST; fif.bus_ack = 1'b0;
        rif.bus_req = NO_REQUEST; rif.bus_ack = 1'b0;
        #3;
        check("rst_grant",  16'(rif.bus_grant), 16'h0);
        check("rst_valid",  16'(rif.grant_valid), 16'h0);
        check("rst_idx",    16'(rif.grant_idx), 16'h0);
        check("rst_to",     16'(rif.timeout_err), 16'h0);
        check("rst_fp",     16'(fif.bus_grant), 16'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // ---- fixed priority ----
        fif.bus_req = 4'b1010;
        tick();
        check("fp_grant",   16'(fif.bus_grant), 16'h2);
        check("fp_idx",     16'(fif.grant_idx), 16'h1);
        check("fp_valid",   16'(fif.grant_valid), 16'h1);
        fif.bus_ack = 1'b1;
        tick();
        check("fp_ack_same", 16'(fif.bus_grant), 16'h2);
        fif.bus_ack = 1'b0; fif.bus_req = 4'b0000;
        tick();
        check("fp_hold",    16'(fif.bus_grant), 16'h2);
        fif.bus_ack = 1'b1;
        tick();
        check("fp_release", 16'(fif.bus_grant), 16'h0);
        check("fp_rel_vld", 16'(fif.grant_valid), 16'h0);
        fif.bus_ack = 1'b0; fif.bus_req = 4'b1000;
        tick();
        check("fp_m3",      16'(fif.bus_grant), 16'h8);
        check("fp_m3_idx",  16'(fif.grant_idx), 16'h3);
        fif.bus_req = 4'b1001; fif.bus_ack = 1'b1;
        tick();
        check("fp_m0",      16'(fif.bus_grant), 16'h1);
        fif.bus_req = 4'b0000;
        tick();
        fif.bus_ack = 1'b0;

        // ---- round robin, ack every 3rd cycle ----
        rif.bus_req = 4'b1111;
        tick();
        for (int k = 0; k < 5; k++) begin
            check($sformatf("rr_load%0d", k), 16'(rif.bus_grant), 16'(rr_seq[k]));
            check($sformatf("rr_vld%0d", k),  16'(rif.grant_valid), 16'h1);
            tick();
            check($sformatf("rr_hold%0d", k), 16'(rif.bus_grant), 16'(rr_seq[k]));
            tick();
            rif.bus_ack = 1'b1;
            if (k == 4) rif.bus_req = 4'b0000;
            tick();
            rif.bus_ack = 1'b0;
        end
        check("rr_to_idle", 16'(rif.bus_grant), 16'h0);
        // ack in IDLE does nothing
        rif.bus_ack = 1'b1;
        tick();
        check("idle_ack",   16'(rif.grant_valid), 16'h0);
        rif.bus_ack = 1'b0;

        // ---- hold without ack (ptr=0 -> master 2 wins) ----
        rif.bus_req = 4'b0100;
        tick();
        check("hold_load",  16'(rif.bus_grant), 16'h4);
        rif.bus_req = 4'b0000;
`ifdef BUS_ARBITER_TIMEOUT_EN
        repeat (3) tick();
`else
        repeat (10) tick();
`endif
        check("hold_grant", 16'(rif.bus_grant), 16'h4);
        check("hold_to",    16'(rif.timeout_err), 16'h0);
        rif.bus_ack = 1'b1;
        tick();
        rif.bus_ack = 1'b0;
        check("hold_rel",   16'(rif.bus_grant), 16'h0);
        tick();
        check("hold_idle",  16'(rif.grant_valid), 16'h0);

        // ---- async reset mid-tenure (ptr=2 -> master 3) ----
        rif.bus_req = 4'b1000;
        tick();
        check("ar_load",    16'(rif.bus_grant), 16'h8);
        rif.bus_req = 4'b1001;
        #2 reset_n = 1'b0;
        #1;
        check("ar_drop",    16'(rif.bus_grant), 16'h0);
        check("ar_vld",     16'(rif.grant_valid), 16'h0);
        #1 reset_n = 1'b1;
        tick();
        check("ar_after",   16'(rif.bus_grant), 16'h1);
        rif.bus_req = 4'b0000; rif.bus_ack = 1'b1;
        tick();
        rif.bus_ack = 1'b0;
        check("ar_idle",    16'(rif.bus_grant), 16'h0);

`ifdef BUS_ARBITER_TIMEOUT_EN
        // ---- watchdog: ptr=0, req 0101 -> master 2 ----
        rif.bus_req = 4'b0101;
        tick();
        check("to_load",    16'(rif.bus_grant), 16'h4);
        repeat (4) tick();
        check("to_pre_g",   16'(rif.bus_grant), 16'h4);
        check("to_pre_e",   16'(rif.timeout_err), 16'h0);
        tick();
        check("to_grant",   16'(rif.bus_grant), 16'h1);
        check("to_pulse",   16'(rif.timeout_err), 16'h1);
        tick();
        check("to_once",    16'(rif.timeout_err), 16'h0);
        check("to_keep",    16'(rif.bus_grant), 16'h1);
        // back to master 2 via a normal ack, then ack exactly in the timeout cycle
        rif.bus_ack = 1'b1;
        tick();
        rif.bus_ack = 1'b0;
        check("to2_load",   16'(rif.bus_grant), 16'h4);
        repeat (4) tick();
        rif.bus_ack = 1'b1;
        tick();
        rif.bus_ack = 1'b0;
        check("to2_grant",  16'(rif.bus_grant), 16'h1);
        check("to2_noerr",  16'(rif.timeout_err), 16'h0);
        rif.bus_req = 4'b0000; rif.bus_ack = 1'b1;
        tick();
        rif.bus_ack = 1'b0;
        check("to2_idle",   16'(rif.bus_grant), 16'h0);
`endif

        // ---- random invariant sweep ----
        prev_grant = rif.bus_grant;
        prev_req   = 4'b0000;
        prev_ack   = 1'b0;
        for (int c = 0; c < 400; c++) begin
            rif.bus_req = 4'($urandom_range(0, 15));
            rif.bus_ack = ($urandom_range(0, 3) == 0);
            prev_req = rif.bus_req;
            prev_ack = rif.bus_ack;
            tick();
            check("inv_onehot", 16'($onehot0(rif.bus_grant)), 16'h1);
            check("inv_valid",  16'(rif.grant_valid), 16'(rif.bus_grant != 4'b0000));
            if (rif.grant_valid)
                check("inv_idx", 16'(rif.bus_grant), 16'(4'b0001 << rif.grant_idx));
            if (prev_grant != 4'b0000 && !prev_ack && !rif.timeout_err)
                check("inv_held", 16'(rif.bus_grant), 16'(prev_grant));
            if (prev_grant == 4'b0000 && prev_req == 4'b0000)
                check("inv_idle", 16'(rif.bus_grant), 16'h0);
            prev_grant = rif.bus_grant;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
